// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar round-robin scheduler.
package sonar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_FIRE   = 2'd2,
    ST_WAIT   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_SLOT_CYCLES = 3_000_000;
  // Shortest slot that still contains the full sr04 internal timeout.
  localparam int MIN_SLOT_CYCLES     = (1 << 19) + 1024;
  localparam int DIST_W              = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_rr_pick.sv
// Combinational round-robin finder: lowest set mask bit at or after start,
// wrapping modulo N.
module sonar_rr_pick
  import sonar_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             wrapped
);

  logic [2*N-1:0]   mask2;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so that bit 0 of rot corresponds to the start index.
  assign mask2 = {mask, mask};
  assign rot   = N'(mask2 >> start);
  assign found = |mask;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
  end

  assign sum = {1'b0, start} + {1'b0, off};

  always_comb begin
    wrapped = 1'b0;
    idx     = sum[IDX_W-1:0];
    if (sum >= (IDX_W+1)'(N)) begin
      wrapped = found;
      idx     = IDX_W'(sum - (IDX_W+1)'(N));
    end
  end

endmodule

// File: rtl/sonar_sched.sv
// Round-robin fire/listen scheduler for a bank of sr04 sonar front-ends;
// one sensor owns each fixed-length slot and its first valid is latched.
module sonar_sched
  import sonar_pkg::*;
#(
  parameter int NUM_SONAR   = 4,
  parameter int SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
  parameter int IDX_W       = idx_width(NUM_SONAR)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SONAR-1:0]          sonar_mask,
  output logic [NUM_SONAR-1:0]          sync_out,
  input  logic [NUM_SONAR-1:0]          sr_valid,
  input  logic [DIST_W*NUM_SONAR-1:0]   sr_dist,
  output logic [DIST_W*NUM_SONAR-1:0]   dist_out,
  output logic [NUM_SONAR-1:0]          new_data,
  input  logic [NUM_SONAR-1:0]          new_clr,
  output logic [NUM_SONAR-1:0]          timeout_flag,
  output logic [IDX_W-1:0]              active_idx,
  output logic                          busy,
  output logic                          cycle_done
);

  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SONAR - 1);

  sched_state_t          state_reg;
  logic [IDX_W-1:0]      active_idx_reg;
  logic [IDX_W-1:0]      start_reg;
  logic                  first_reg;
  logic                  captured_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [NUM_SONAR-1:0]  sync_reg;
  logic [NUM_SONAR-1:0]  new_data_reg;
  logic [NUM_SONAR-1:0]  timeout_reg;
  logic                  cycle_done_reg;
  logic [DIST_W-1:0]     dist_reg    [NUM_SONAR];
  logic [DIST_W-1:0]     sr_dist_arr [NUM_SONAR];
  logic [NUM_SONAR-1:0]  new_set;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  pick_wrapped;
  logic                  hit;

  sonar_rr_pick #(
    .N     (NUM_SONAR),
    .IDX_W (IDX_W)
  ) u_pick (
    .mask    (sonar_mask),
    .start   (start_reg),
    .idx     (pick_idx),
    .found   (pick_found),
    .wrapped (pick_wrapped)
  );

  // First valid from the slot owner only; later ones in the slot are dropped.
  assign hit = (state_reg == ST_WAIT) && sr_valid[active_idx_reg] && !captured_reg;

  generate
    for (genvar gi = 0; gi < NUM_SONAR; gi++) begin : g_lane
      assign sr_dist_arr[gi]                = sr_dist[gi*DIST_W +: DIST_W];
      assign dist_out[gi*DIST_W +: DIST_W]  = dist_reg[gi];
      assign new_set[gi]                    = hit && (active_idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      active_idx_reg <= '0;
      start_reg      <= '0;
      first_reg      <= 1'b0;
      captured_reg   <= 1'b0;
      count_reg      <= '0;
      sync_reg       <= '0;
      new_data_reg   <= '0;
      timeout_reg    <= '0;
      cycle_done_reg <= 1'b0;
      for (int i = 0; i < NUM_SONAR; i++) dist_reg[i] <= '0;
    end else begin
      sync_reg       <= '0;
      cycle_done_reg <= 1'b0;
      // A capture wins over a same-cycle clear on the same bit.
      new_data_reg   <= (new_data_reg & ~new_clr) | new_set;

      if (hit) begin
        dist_reg[active_idx_reg]    <= sr_dist_arr[active_idx_reg];
        timeout_reg[active_idx_reg] <= 1'b0;
        captured_reg                <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (enable && (|sonar_mask)) begin
            state_reg <= ST_SELECT;
            start_reg <= '0;
            first_reg <= 1'b1;
          end
        end

        ST_SELECT: begin
          if (!pick_found) begin
            state_reg <= ST_IDLE;
          end else begin
            active_idx_reg <= pick_idx;
            sync_reg       <= NUM_SONAR'(1) << pick_idx;
            // Chosen index <= previous one exactly when the search wrapped,
            // or when the previous slot was the top index (search restarted at 0).
            cycle_done_reg <= !first_reg && (pick_wrapped || active_idx_reg == LAST_IDX);
            first_reg      <= 1'b0;
            state_reg      <= ST_FIRE;
          end
        end

        ST_FIRE: begin
          count_reg    <= '0;
          captured_reg <= 1'b0;
          state_reg    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (count_reg == SLOT_LAST) begin
            if (!captured_reg && !hit) timeout_reg[active_idx_reg] <= 1'b1;
            start_reg <= (active_idx_reg == LAST_IDX) ? '0 : active_idx_reg + IDX_W'(1);
            state_reg <= enable ? ST_SELECT : ST_IDLE;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sync_out     = sync_reg;
  assign new_data     = new_data_reg;
  assign timeout_flag = timeout_reg;
  assign active_idx   = active_idx_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign cycle_done   = cycle_done_reg;

endmodule
